control_unit: RTL and testbench

Multi-cycle control FSM for the 16-bit processor. Sits directly upstream of the register-file/immediate/write-back datapath block and drives its `input_reg_write`, `memToReg` and `input_branch` controls, plus the fetch, memory and ALU-stage selects. Sequences each instruction through fetch, decode, execute, memory and write-back states, stalling on a memory ready handshake. Also keeps a retired-instruction counter.

---
 rtl/control_unit_if.sv | 39 +++
 rtl/control_unit.sv | 169 ++++++++++++++++
 tb/tb_control_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Control bundle between the multi-cycle control FSM and the datapath it steers.
// The FSM drives every control strobe; the datapath supplies the opcode and memory handshake.
interface control_unit_if #(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                ir_write;
  logic                pc_write;
  logic                branch;
  logic                branch_ne;
  logic                mem_read;
  logic                mem_write;
  logic                iord;
  logic                reg_write;
  logic                mem_to_reg;
  logic [1:0]          reg_dst;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                halted;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  opcode, mem_ready,
    output ir_write, pc_write, branch, branch_ne, mem_read, mem_write, iord,
           reg_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
           halted, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  ir_write, pc_write, branch, branch_ne, mem_read, mem_write, iord,
           reg_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
           halted, instr_count
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-bit processor: fetch/decode/execute/memory/write-back
// sequencing with memory-ready stalls and a retired-instruction counter.
module control_unit #(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned CNT_W    = 16
) (
  input logic              CLK,
  input logic              RST_N,
  control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StExecR, StExecI, StMemAddr, StMemRd, StMemWr,
    StWbAlu, StWbMem, StBranch, StJump, StHalt
  } state_e;

  typedef enum logic [2:0] {
    OpR    = 3'b000,
    OpLw   = 3'b001,
    OpAddi = 3'b010,
    OpSw   = 3'b011,
    OpJal  = 3'b100,
    OpBeq  = 3'b101,
    OpBne  = 3'b110,
    OpHalt = 3'b111
  } opcode_e;

  state_e           r_state, w_state_next;
  opcode_e          r_opcode;
  opcode_e          w_opcode;
  logic [CNT_W-1:0] r_count;
  logic             w_retire;

  assign w_opcode        = opcode_e'(bus.opcode[2:0]);
  assign bus.instr_count = r_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= StIdle;
      r_opcode <= OpR;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      // Later stages decide from this copy, so the live opcode is don't-care after DECODE.
      if (r_state == StDecode) r_opcode <= w_opcode;
      if (w_retire)            r_count  <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_retire       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.branch_ne  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_source  = 2'b00;
    bus.halted     = 1'b0;

    unique case (r_state)
      StIdle: w_state_next = StFetch;

      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) w_state_next = StDecode;
      end

      StDecode: begin
        bus.alu_src_b = 2'b10;
        unique case (w_opcode)
          OpR:          w_state_next = StExecR;
          OpLw, OpSw:   w_state_next = StMemAddr;
          OpAddi:       w_state_next = StExecI;
          OpJal:        w_state_next = StJump;
          OpBeq, OpBne: w_state_next = StBranch;
          OpHalt: begin
            w_state_next = StHalt;
            w_retire     = 1'b1;
          end
          default:      w_state_next = StHalt;
        endcase
      end

      StExecR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        w_state_next  = StWbAlu;
      end

      StExecI: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        w_state_next  = StWbAlu;
      end

      StMemAddr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        w_state_next  = (r_opcode == OpSw) ? StMemWr : StMemRd;
      end

      StMemRd: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) w_state_next = StWbMem;
      end

      StMemWr: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = StFetch;
          w_retire     = 1'b1;
        end
      end

      StWbAlu: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (r_opcode == OpR) ? 2'b00 : 2'b01;
        w_state_next  = StFetch;
        w_retire      = 1'b1;
      end

      StWbMem: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.reg_dst    = 2'b01;
        w_state_next   = StFetch;
        w_retire       = 1'b1;
      end

      StBranch: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_source = 2'b01;
        bus.branch    = (r_opcode == OpBeq);
        bus.branch_ne = (r_opcode == OpBne);
        w_state_next  = StFetch;
        w_retire      = 1'b1;
      end

      StJump: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b10;
        w_state_next  = StFetch;
        w_retire      = 1'b1;
      end

      StHalt: bus.halted = 1'b1;

      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: an instruction-level model predicts every control output
// and the retired count each cycle; directed sections pin the model with literal expectations.
module tb_control_unit;

  typedef struct packed {
    logic       ir_write, pc_write, branch, branch_ne, mem_read, mem_write, iord;
    logic       reg_write, mem_to_reg;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       halted;
  } ctl_t;

  typedef enum {PhF, PhD, PhExR, PhExI, PhMA, PhMR, PhMW, PhWbA, PhWbM, PhBr, PhJ} ph_e;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  control_unit_if #(.OPCODE_W(3), .CNT_W(16)) bus ();
  control_unit_if #(.OPCODE_W(3), .CNT_W(4))  bus4 ();

  control_unit #(.OPCODE_W(3), .CNT_W(16)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  control_unit #(.OPCODE_W(3), .CNT_W(4))  dut4 (.CLK(clk), .RST_N(rst_n), .bus(bus4));

  assign bus4.opcode    = bus.opcode;
  assign bus4.mem_ready = bus.mem_ready;

  always #5 clk = ~clk;

  ctl_t dut_ctl, dut4_ctl;
  assign dut_ctl  = {bus.ir_write, bus.pc_write, bus.branch, bus.branch_ne, bus.mem_read,
                     bus.mem_write, bus.iord, bus.reg_write, bus.mem_to_reg, bus.reg_dst,
                     bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.halted};
  assign dut4_ctl = {bus4.ir_write, bus4.pc_write, bus4.branch, bus4.branch_ne, bus4.mem_read,
                     bus4.mem_write, bus4.iord, bus4.reg_write, bus4.mem_to_reg, bus4.reg_dst,
                     bus4.alu_src_a, bus4.alu_src_b, bus4.alu_op, bus4.pc_source, bus4.halted};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction model: each opcode is a fixed list of phases, phase 0 fetch and 1 decode.
  function automatic int last_step(input int op);
    case (op)
      1:       return 4;
      0, 2, 3: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic ph_e phase(input int op, input int step);
    if (step == 0) return PhF;
    if (step == 1) return PhD;
    case (op)
      0:       return (step == 2) ? PhExR : PhWbA;
      2:       return (step == 2) ? PhExI : PhWbA;
      1:       return (step == 2) ? PhMA : (step == 3) ? PhMR : PhWbM;
      3:       return (step == 2) ? PhMA : PhMW;
      4:       return PhJ;
      default: return PhBr;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input ph_e ph, input int op, input logic rdy);
    ctl_t c = '0;
    case (ph)
      PhF:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      PhD:  c.alu_src_b = 2'b10;
      PhExR: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      PhExI, PhMA: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      PhMR: begin c.mem_read = 1; c.iord = 1; end
      PhMW: begin c.mem_write = 1; c.iord = 1; end
      PhWbA: begin c.reg_write = 1; c.reg_dst = (op == 0) ? 2'b00 : 2'b01; end
      PhWbM: begin c.reg_write = 1; c.mem_to_reg = 1; c.reg_dst = 2'b01; end
      PhBr: begin
        c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01;
        c.branch = (op == 5); c.branch_ne = (op == 6);
      end
      PhJ:  begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  bit          m_idle = 1, m_halted = 0;
  int          m_step = 0, m_op = 0;
  int unsigned m_count = 0;

  always @(negedge clk) begin
    ctl_t e;
    ph_e  ph;
    int unsigned ec;
    e  = '0;
    ec = rst_n ? m_count : 0;
    if (rst_n && m_halted) e.halted = 1'b1;
    else if (rst_n && !m_idle) e = expect_ctl(phase(m_op, m_step), m_op, bus.mem_ready);
    chk("ctl", 32'(dut_ctl), 32'(e));
    chk("ctl_w4", 32'(dut4_ctl), 32'(e));
    chk("count", 32'(bus.instr_count), 32'(16'(ec)));
    chk("count_w4", 32'(bus4.instr_count), 32'(4'(ec)));

    if (!rst_n) begin
      m_idle = 1; m_halted = 0; m_step = 0; m_count = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_idle) begin
      m_idle = 0; m_step = 0;
    end else begin
      if (m_step == 1) m_op = int'(bus.opcode);
      ph = phase(m_op, m_step);
      if (m_step == 1 && m_op == 7) begin
        m_halted = 1; m_count++;
      end else if (!((ph == PhF || ph == PhMR || ph == PhMW) && !bus.mem_ready)) begin
        if (m_step == last_step(m_op)) begin
          m_step = 0; m_count++;
        end else m_step++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    logic pat [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int ir_pulses;
    rst_n = 1'b0; bus.opcode = 3'd2; bus.mem_ready = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;

    // addi: FETCH, DECODE, EXEC_I, WB_ALU
    cyc(); look();
    chk("fetch_ir_write", 32'(bus.ir_write), 1);
    chk("fetch_pc_write", 32'(bus.pc_write), 1);
    repeat (3) cyc();
    look();
    chk("addi_wb_reg_write", 32'(bus.reg_write), 1);
    chk("addi_wb_reg_dst", 32'(bus.reg_dst), 1);
    chk("addi_wb_mem_to_reg", 32'(bus.mem_to_reg), 0);

    // lw with two fetch stalls and one MEM_RD stall: 8 cycles
    ir_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus.opcode = 3'd1; bus.mem_ready = pat[i];
      look();
      if (i == 0) chk("addi_retired", 32'(bus.instr_count), 1);
      if (bus.ir_write) ir_pulses++;
      if (i == 7) chk("lw_wb_mem_to_reg", 32'(bus.mem_to_reg), 1);
    end
    chk("lw_ir_pulses", 32'(ir_pulses), 1);

    // jal then bne; opcode scrambled outside DECODE
    for (int i = 0; i < 6; i++) begin
      cyc();
      bus.mem_ready = 1'b1;
      bus.opcode = (i == 1) ? 3'd4 : (i == 4) ? 3'd6 : 3'($urandom_range(0, 7));
      look();
      if (i == 0) begin
        chk("lw_retired", 32'(bus.instr_count), 2);
        chk("lw_next_fetch", 32'(bus.mem_read), 1);
      end
      if (i == 2) begin
        chk("jal_reg_dst", 32'(bus.reg_dst), 2);
        chk("jal_pc_source", 32'(bus.pc_source), 2);
        chk("jal_reg_write", 32'(bus.reg_write), 1);
      end
      if (i == 5) begin
        chk("bne_branch_ne", 32'(bus.branch_ne), 1);
        chk("bne_branch", 32'(bus.branch), 0);
        chk("bne_alu_op", 32'(bus.alu_op), 1);
      end
    end

    // sw aborted by reset in MEM_WR
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.opcode = (i == 1) ? 3'd3 : 3'($urandom_range(0, 7));
      bus.mem_ready = (i == 3) ? 1'b0 : 1'b1;
      look();
      if (i == 0) chk("jal_bne_retired", 32'(bus.instr_count), 4);
      if (i == 3) chk("sw_mem_write", 32'(bus.mem_write), 1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("sw_abort_mem_write", 32'(bus.mem_write), 0);
    chk("sw_abort_count", 32'(bus.instr_count), 0);
    cyc();
    cyc();
    rst_n = 1'b1; bus.opcode = 3'd7; bus.mem_ready = 1'b1;

    // halt, then opcode noise
    repeat (3) cyc();
    look();
    chk("halt_halted", 32'(bus.halted), 1);
    chk("halt_count", 32'(bus.instr_count), 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      bus.opcode = 3'($urandom_range(0, 7)); bus.mem_ready = 1'($urandom_range(0, 1));
      look();
      chk("halt_hold", 32'({bus.halted, bus.mem_read, bus.instr_count}), 32'({2'b10, 16'd1}));
    end

    // 16 addi retires: the 4-bit counter wraps to 0
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; bus.opcode = 3'd2; bus.mem_ready = 1'b1;
    repeat (65) cyc();
    look();
    chk("wrap_count16", 32'(bus.instr_count), 16);
    chk("wrap_count4", 32'(bus4.instr_count), 0);

    // Random traffic; reset now and then, and soon after a halt
    for (int i = 0; i < 4000; i++) begin
      cyc();
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.opcode = ($urandom_range(0, 29) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      rst_n = !((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0);
    end
    cyc();
    look();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
